// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard unit for the 5-stage RV32 core.
//
// Produces forwarding selects for the two Execute operands, pipeline stall
// and flush strobes, a data-memory wait-state tracker with a sticky timeout
// flag, and optional saturating performance counters.
//
// Parameters:
//   TIMEOUT  consecutive memory-wait cycles before MemErr is set (1..255)
//   CNT_W    width of each performance counter
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   Rs1D, Rs2D                       Decode source registers
//   Rs1E, Rs2E, RdE                  Execute source/destination registers
//   RdM, RdW                         Memory/Writeback destination registers
//   ResultSrcEb0                     Execute instruction is a load
//   PCSrcE                           taken branch/jump in Execute
//   RegWriteM, RegWriteW             register-write enables in M and W
//   MemReqM, MemReadyM               data-memory request / completion in M
//   ForwardAE, ForwardBE             00 = RF, 01 = W result, 10 = M ALU result
//   StallF/D/E/M, FlushD/E/W         pipeline register holds and clears
//   MemErr                           sticky memory-timeout flag
//   StallCount, FlushCount, WaitCount performance counters
//
// Build option: define HAZARD_PERF_CNT_EN to build the performance counters;
// otherwise the three counter outputs are tied to zero.

module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcEb0,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [CNT_W-1:0] WaitCount
);

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    typedef enum logic {StRun, StWait} state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       mem_stall;
    logic       lw_stall;

    // M stage has priority: it holds the younger write to the register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                           input logic [4:0] rd_m, input logic wr_w,
                                           input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign mem_stall = MemReqM & ~MemReadyM;
    assign lw_stall  = ResultSrcEb0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            if (mem_stall) begin
                // Freeze the whole pipe; a pending branch stays in E and
                // resolves once the access completes. W gets a bubble.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
            end
        end
    end

    // Wait tracker: the first stalled cycle (still in RUN) counts zero.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | (wait_cnt_q == TimeoutVal);
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d    = StWait;
                    wait_cnt_d = 8'd0;
                end
            end
            StWait: begin
                if (!mem_stall) begin
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q != TimeoutVal) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_pc_q, wait_pc_d;

    // Saturating increments: a counter parks at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_pc_d   = wait_pc_q;
        if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (mem_stall && (wait_pc_q != '1)) wait_pc_d = wait_pc_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_pc_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_pc_q   <= wait_pc_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
    assign WaitCount  = wait_pc_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
    assign WaitCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// behavioural model. The model tracks memory waits as the length of the run
// of consecutive stalled cycles rather than as a state machine.

module tb_hazard_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          ResultSrcEb0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCount, FlushCount, WaitCount;

    hazard_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .ResultSrcEb0(ResultSrcEb0),
        .PCSrcE      (PCSrcE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .MemErr      (MemErr),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount),
        .WaitCount   (WaitCount)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model state
    int            m_run;   // consecutive stalled cycles just before this one
    bit            m_err;
    logic [CW-1:0] m_sc, m_fc, m_wc;
    bit            e_ms, e_sf, e_fd;

    task automatic check(input string tag, input logic [CW-1:0] obs,
                         input logic [CW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'd2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check_all(input string step);
        bit ms, lw, sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        ms = MemReqM && !MemReadyM;
        lw = ResultSrcEb0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        fa = fwd_model(Rs1E);
        fb = fwd_model(Rs2E);
        if (ms) begin
            {sf, sd, se, sm, fw} = '1;
            {fd, fe} = '0;
        end else begin
            sf = lw; sd = lw; fd = PCSrcE; fe = lw || PCSrcE;
            {se, sm, fw} = '0;
        end
        if (!reset) begin
            {sf, sd, se, sm, fd, fe, fw} = '0;
            fa = 2'd0; fb = 2'd0;
        end
        e_ms = ms; e_sf = sf; e_fd = fd;
        check({step, ".ForwardAE"}, CW'(ForwardAE), CW'(fa));
        check({step, ".ForwardBE"}, CW'(ForwardBE), CW'(fb));
        check({step, ".StallF"}, CW'(StallF), CW'(sf));
        check({step, ".StallD"}, CW'(StallD), CW'(sd));
        check({step, ".StallE"}, CW'(StallE), CW'(se));
        check({step, ".StallM"}, CW'(StallM), CW'(sm));
        check({step, ".FlushD"}, CW'(FlushD), CW'(fd));
        check({step, ".FlushE"}, CW'(FlushE), CW'(fe));
        check({step, ".FlushW"}, CW'(FlushW), CW'(fw));
        check({step, ".MemErr"}, CW'(MemErr), CW'(m_err));
`ifdef HAZARD_PERF_CNT_EN
        check({step, ".StallCount"}, StallCount, m_sc);
        check({step, ".FlushCount"}, FlushCount, m_fc);
        check({step, ".WaitCount"}, WaitCount, m_wc);
`else
        check({step, ".StallCount"}, StallCount, '0);
        check({step, ".FlushCount"}, FlushCount, '0);
        check({step, ".WaitCount"}, WaitCount, '0);
`endif
    endtask

    task automatic model_clear();
        m_run = 0; m_err = 0; m_sc = '0; m_fc = '0; m_wc = '0;
    endtask

    // Check the current cycle, then advance the model across one clock edge.
    task automatic step(input string name);
        #1;
        check_all(name);
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            // A wait run longer than TIMEOUT cycles trips the flag.
            if (m_run >= int'(TO) + 1) m_err = 1;
            m_run = e_ms ? m_run + 1 : 0;
            if (e_sf && m_sc != '1) m_sc = m_sc + 1;
            if (e_fd && m_fc != '1) m_fc = m_fc + 1;
            if (e_ms && m_wc != '1) m_wc = m_wc + 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcEb0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        @(posedge clk);
        model_clear();
        @(negedge clk);

        // Reset cycle with hazards present: all strobes must be held low.
        RdM = 5; RegWriteM = 1; Rs1E = 5; ResultSrcEb0 = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        step("reset_gate");
        clear_inputs();
        reset = 1'b1;
        step("idle");

        // Forwarding priority
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        step("fwd_m");
        RegWriteM = 0;
        step("fwd_w");
        Rs2E = 0; RdM = 0;
        step("fwd_x0");
        clear_inputs();

        // Load-use, then load-use with a taken branch
        ResultSrcEb0 = 1; RdE = 7; Rs2D = 7;
        step("lw");
        PCSrcE = 1;
        step("lw_br");
        clear_inputs();
        step("after_lw");

        // Three-cycle memory miss with a branch pending in E
        MemReqM = 1; MemReadyM = 0;
        step("miss0");
        PCSrcE = 1;
        step("miss1");
        step("miss2");
        MemReadyM = 1;
        step("miss_done");
        clear_inputs();
        step("miss_idle");

        // Timeout: MemErr rises on the 6th edge and stays set
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 10; i++) step($sformatf("to%0d", i));
        MemReadyM = 1;
        step("to_ready");
        clear_inputs();
        step("to_idle");
        check("to_sticky", CW'(MemErr), CW'(1));
        reset = 1'b0;
        step("to_reset");
        reset = 1'b1;
        step("to_after_reset");
        check("to_cleared", CW'(MemErr), CW'(0));

        // Randomized traffic; alternate phases of fast and very slow memory
        for (int i = 0; i < 600; i++) begin
            Rs1D = 5'($urandom_range(0, 7));
            Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7));
            Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7));
            RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            ResultSrcEb0 = 1'($urandom_range(0, 1));
            PCSrcE       = ($urandom_range(0, 3) == 0);
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemReqM      = ($urandom_range(0, 3) != 0);
            MemReadyM    = ((i % 200) < 100) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 9) == 0);
            reset        = ($urandom_range(0, 79) != 0);
            step($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer end of the pipeline control interface: takes the E/M/W control bits and register addresses and produces forwarding selects, stall and flush strobes for the 5-stage RV32 core.
- Adds a data-memory wait-state handshake with a timeout watchdog and saturating performance counters.
- Sits beside the controller and datapath; all stall and flush outputs feed pipeline register enables and clears.

Parameters:
- TIMEOUT, 16: consecutive memory-wait cycles before MemErr is set; legal range 1..255.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low; sampled on the clk rising edge
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute
- RdM, RdW  in  5  destination registers in Memory and Writeback
- ResultSrcEb0  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch or jump in Execute
- RegWriteM, RegWriteW  in  1  register-write enables in M and W
- MemReqM  in  1  load or store active in Memory
- MemReadyM  in  1  memory completes the M access this cycle
- ForwardAE, ForwardBE  out  2  00 = RF, 01 = W result, 10 = M ALU result
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register
- MemErr  out  1  sticky memory-timeout flag
- StallCount, FlushCount, WaitCount  out  CNT_W  performance counters

Behaviour:
- While reset=0 (in the reset cycle): every stall, flush and forward output = 0. On the next edge: MemErr=0, all counters=0, FSM=RUN, wait counter=0.
- ForwardAE is combinational and applies at all times, including during stalls:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - else 00.
  - M takes priority over W. ForwardBE uses identical logic on Rs2E.
- memStall = MemReqM & ~MemReadyM (combinational).
- lwStall = ResultSrcEb0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- If memStall=1:
  - StallF = StallD = StallE = StallM = 1, FlushW = 1.
  - FlushD = FlushE = 0. The memory stall wins over load-use and over PCSrcE; the branch is held in E and resolves after the wait.
- If memStall=0:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - StallE = StallM = FlushW = 0.
  - When lwStall and PCSrcE occur together, all four (StallF, StallD, FlushD, FlushE) are asserted.
- FSM, updated on clk edge:
  - RUN -> WAIT when memStall.
  - WAIT -> RUN when MemReadyM, or when MemReqM drops.
  - WAIT -> WAIT otherwise; the wait counter increments and saturates at TIMEOUT.
  - Entering RUN clears the wait counter.
  - When the wait counter reaches TIMEOUT: MemErr <= 1. MemErr stays set until reset. The pipeline keeps stalling; there is no forced abort.
- Wait counter counts cycles spent in WAIT only. The first stalled cycle (RUN with memStall) counts 0; a 3-cycle miss reaches 2.
- Counters saturate at all ones and never wrap; each increments at most once per clock:
  - StallCount +1 every cycle StallF=1.
  - FlushCount +1 every cycle FlushD=1.
  - WaitCount +1 every cycle memStall=1.
- Asserting reset mid-wait: the FSM returns to RUN, MemErr and counters clear, and outputs go to 0 the same cycle.
- Latency: all strobes are combinational, same cycle as their inputs. MemErr is set one cycle after the wait counter reaches TIMEOUT.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: StallCount, FlushCount and WaitCount are implemented as described above.
- HAZARD_PERF_CNT_EN undefined: no counter flops are built; all three outputs are tied to 0. Forwarding, stall, flush, FSM and MemErr are unchanged.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then set RegWriteM=0 -> ForwardAE=01. Set Rs2E=0 with RdM=0 -> ForwardBE=00.
- ResultSrcEb0=1, RdE=7, Rs2D=7, no memStall -> StallF=1, StallD=1, FlushE=1, FlushD=0, StallE=0. StallCount increments by 1.
- PCSrcE=1 together with the load-use case above -> FlushD=1, FlushE=1, StallF=1, StallD=1. FlushCount +1.
- MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> StallF..StallM=1 and FlushW=1 for 3 cycles. PCSrcE=1 during the stall -> FlushD=0. FSM returns to RUN, WaitCount=3, MemErr=0.
- TIMEOUT=4: hold MemReqM=1, MemReadyM=0 for 10 cycles -> MemErr rises on the 6th clock edge after MemReqM is raised and stays 1 after MemReadyM=1. A following reset=0 for 1 cycle -> MemErr=0 and counters=0.
- Compile without HAZARD_PERF_CNT_EN, repeat the scenarios above -> all counters read 0; every other response is identical.
